// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared constants for the counter sequencer: the 3-bit FSM state encoding
// (also exported on state_o), the fixed LED patterns, and a helper that maps
// a state plus the 4-bit counter view onto the LED value.
package counter_seq_pkg;

    localparam logic [2:0] CLEAR = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [3:0] LED_CLEAR = 4'hF;
    localparam logic [3:0] LED_IDLE  = 4'h0;
    localparam logic [3:0] LED_DONE  = 4'hA;

    // RUN and HOLD show the live count; every other state shows a fixed pattern.
    function automatic logic [3:0] led_pattern(input logic [2:0] st,
                                               input logic [3:0] cnt);
        logic [3:0] pattern;
        pattern = LED_IDLE;
        case (st)
            CLEAR:     pattern = LED_CLEAR;
            RUN, HOLD: pattern = cnt;
            DONE:      pattern = LED_DONE;
            default:   pattern = LED_IDLE;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// tick_gen
// Parameterised prescaler. Counts 0..PRESCALE-1 while run is high and holds
// its value otherwise; restart forces the count back to zero. tick is high
// on the last count of each period, but only while running.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   run      advance the prescaler this cycle
//   restart  synchronous return to count zero (wins over run)
//   tick     combinational end-of-period strobe
module tick_gen #(
    parameter int PRESCALE = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    // Free-running modulo-PRESCALE counter, frozen when not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = run & (count == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer
// Sequences the external 4-bit clock_counter: synchronises the two user
// switches, runs the CLEAR/IDLE/RUN/HOLD(/DONE) command FSM, produces the
// counter's synchronous reset and prescaled single-cycle enable, and drives
// the LEDs, the encoded state and a saturating wrap counter.
// Optional feature macro: COUNTER_SEQ_AUTO_STOP_EN -- when defined, the
// counter stops at all-ones (state DONE) instead of wrapping.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   switches    async inputs: [0] run level, [1] clear on rising edge
//   counter_in  current clock_counter value
//   cnt_rst     synchronous active-high reset to clock_counter
//   cnt_en      single-cycle count enable to clock_counter
//   leds        registered display value
//   state_o     encoded FSM state
//   wraps       saturating count of counter wrap-arounds since last clear
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int PRESCALE   = 100000000,
    parameter int CLR_CYCLES = 4,
    parameter int WRAP_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        switches,
    input  logic [CNT_W-1:0]  counter_in,
    output logic              cnt_rst,
    output logic              cnt_en,
    output logic [3:0]        leds,
    output logic [2:0]        state_o,
    output logic [WRAP_W-1:0] wraps
);

    localparam int CLRW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLRW-1:0] CLR_LAST = CLRW'(CLR_CYCLES - 1);

    logic [1:0]      sync1;
    logic [1:0]      sw_s;
    logic            sw1_d;
    logic            clr_pulse;
    logic [2:0]      state;
    logic [2:0]      next_state;
    logic [CLRW-1:0] clr_cnt;
    logic            tick;
    logic            in_run;
    logic            run_entry;
    logic            cnt_all_ones;
    logic [3:0]      cnt4;

    // Two-flop synchroniser for both switches, plus one extra stage on the
    // clear switch so its rising edge becomes a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sw_s  <= '0;
            sw1_d <= 1'b0;
        end else begin
            sync1 <= switches;
            sw_s  <= sync1;
            sw1_d <= sw_s[1];
        end
    end

    assign clr_pulse    = sw_s[1] & ~sw1_d;
    assign cnt_all_ones = &counter_in;
    assign in_run       = (state == RUN);

    // LEDs show the low four bits of the counter, zero-extended if narrower.
    generate
        if (CNT_W >= 4) begin : g_cnt_trunc
            assign cnt4 = counter_in[3:0];
        end else begin : g_cnt_ext
            assign cnt4 = {{(4 - CNT_W){1'b0}}, counter_in};
        end
    endgenerate

    // Command FSM. A clear pulse beats everything, including the run switch
    // in the same cycle, and re-enters CLEAR even from CLEAR itself.
    always_comb begin
        next_state = state;
        if (clr_pulse) begin
            next_state = CLEAR;
        end else begin
            case (state)
                CLEAR: if (clr_cnt == CLR_LAST) next_state = sw_s[0] ? RUN : IDLE;
                IDLE:  if (sw_s[0]) next_state = RUN;
                RUN: begin
                    if (!sw_s[0]) begin
                        next_state = HOLD;
                    end
`ifdef COUNTER_SEQ_AUTO_STOP_EN
                    else if (tick && cnt_all_ones) begin
                        next_state = DONE;
                    end
`endif
                end
                HOLD:  if (sw_s[0]) next_state = RUN;
`ifdef COUNTER_SEQ_AUTO_STOP_EN
                DONE:  next_state = DONE;
`endif
                default: next_state = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= next_state;
        end
    end

    // Clear-window counter: reloaded by every clear pulse, runs up to
    // CLR_LAST while in CLEAR. Reset leaves it at zero so a reset behaves
    // exactly like a fresh clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (clr_pulse) begin
            clr_cnt <= '0;
        end else if ((state == CLEAR) && (clr_cnt != CLR_LAST)) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Every entry to RUN restarts the prescaler so the first enable comes a
    // full PRESCALE period after entry.
    assign run_entry = (next_state == RUN) && !in_run;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (in_run),
        .restart(run_entry),
        .tick   (tick)
    );

    // Enable is registered from the tick, and dropped when the FSM is leaving
    // RUN on that cycle (pause, clear or auto-stop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_en <= 1'b0;
        end else begin
            cnt_en <= tick && (next_state == RUN);
        end
    end

    assign cnt_rst = (state == CLEAR);
    assign state_o = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds <= LED_IDLE;
        end else begin
            leds <= led_pattern(state, cnt4);
        end
    end

`ifdef COUNTER_SEQ_AUTO_STOP_EN
    // The counter never wraps when auto-stop is built in.
    assign wraps = '0;
`else
    // A wrap is an enable landing on an all-ones counter; saturate at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wraps <= '0;
        end else if (clr_pulse) begin
            wraps <= '0;
        end else if (cnt_en && cnt_all_ones && (wraps != {WRAP_W{1'b1}})) begin
            wraps <= wraps + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
// Directed plus random stimulus for counter_sequencer with PRESCALE = 4,
// CLR_CYCLES = 4, CNT_W = 4, WRAP_W = 8. A behavioural clock_counter is
// attached to the DUT, and a cycle model built from the sequencing rules
// predicts every output.
module tb_counter_sequencer;

    localparam int P   = 4;
    localparam int CLR = 4;
`ifdef COUNTER_SEQ_AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] switches = 2'b00;
    logic [3:0] counter_in = 4'h0;
    logic       cnt_rst;
    logic       cnt_en;
    logic [3:0] leds;
    logic [2:0] state_o;
    logic [7:0] wraps;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int         m_mode;
    int         m_clr_left;
    int         m_age;
    int         m_cnt;
    int         m_wraps;
    logic [3:0] m_leds;
    bit         m_en;
    logic [1:0] hist [3];

    counter_sequencer #(
        .CNT_W(4), .PRESCALE(P), .CLR_CYCLES(CLR), .WRAP_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .switches(switches), .counter_in(counter_in),
        .cnt_rst(cnt_rst), .cnt_en(cnt_en), .leds(leds), .state_o(state_o),
        .wraps(wraps)
    );

    always #5 clk = ~clk;

    // Behavioural clock_counter driven by the sequencer
    always @(posedge clk) begin
        if (cnt_rst) counter_in <= 4'h0;
        else if (cnt_en) counter_in <= counter_in + 4'h1;
    end

    task automatic modelReset();
        m_mode = 0; m_clr_left = CLR; m_age = 0; m_cnt = 0;
        m_wraps = 0; m_leds = 4'h0; m_en = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = 2'b00;
    endtask

    // One clock edge of the specified behaviour, from pre-edge values.
    task automatic modelEdge();
        logic [1:0] sw_s;
        bit         pulse;
        bit         tick;
        int         nxt;
        logic [3:0] leds_n;
        int         wraps_n;
        int         cnt_n;
        sw_s  = hist[1];
        pulse = hist[1][1] && !hist[2][1];
        tick  = (m_mode == 2) && ((m_age % P) == P - 1);
        nxt   = m_mode;
        if (pulse) nxt = 0;
        else begin
            case (m_mode)
                0: if (m_clr_left == 1) nxt = sw_s[0] ? 2 : 1;
                1: if (sw_s[0]) nxt = 2;
                2: begin
                    if (!sw_s[0]) nxt = 3;
                    else if (AUTO && tick && m_cnt == 15) nxt = 4;
                end
                3: if (sw_s[0]) nxt = 2;
                default: nxt = m_mode;
            endcase
        end
        case (m_mode)
            0: leds_n = 4'hF;
            2, 3: leds_n = 4'(m_cnt);
            4: leds_n = 4'hA;
            default: leds_n = 4'h0;
        endcase
        wraps_n = m_wraps;
        if (pulse) wraps_n = 0;
        else if (!AUTO && m_en && m_cnt == 15 && m_wraps < 255) wraps_n = m_wraps + 1;
        cnt_n = m_cnt;
        if (m_mode == 0) cnt_n = 0;
        else if (m_en) cnt_n = (m_cnt + 1) % 16;
        if (pulse) m_clr_left = CLR;
        else if (m_mode == 0) m_clr_left = m_clr_left - 1;
        if (nxt == 2 && m_mode != 2) m_age = 0;
        else if (m_mode == 2) m_age = m_age + 1;
        m_en    = tick && (nxt == 2);
        m_mode  = nxt;
        m_leds  = leds_n;
        m_wraps = wraps_n;
        m_cnt   = cnt_n;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = switches;
    endtask

    task automatic checkValue(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        vectors++;
        assert (state_o === 3'(m_mode)) else begin
            miscompares++;
            $error("[TB] FAIL state_o: got %0d expected %0d", state_o, m_mode);
        end
        vectors++;
        assert (cnt_rst === (m_mode == 0)) else begin
            miscompares++;
            $error("[TB] FAIL cnt_rst: got %0b expected %0b", cnt_rst, (m_mode == 0));
        end
        vectors++;
        assert (cnt_en === m_en) else begin
            miscompares++;
            $error("[TB] FAIL cnt_en: got %0b expected %0b", cnt_en, m_en);
        end
        vectors++;
        assert (leds === m_leds) else begin
            miscompares++;
            $error("[TB] FAIL leds: got %0h expected %0h", leds, m_leds);
        end
        vectors++;
        assert (wraps === 8'(m_wraps)) else begin
            miscompares++;
            $error("[TB] FAIL wraps: got %0d expected %0d", wraps, m_wraps);
        end
        vectors++;
        assert (counter_in === 4'(m_cnt)) else begin
            miscompares++;
            $error("[TB] FAIL counter: got %0h expected %0h", counter_in, m_cnt);
        end
        vectors++;
        assert (!(cnt_rst === 1'b1 && cnt_en === 1'b1)) else begin
            miscompares++;
            $error("[TB] FAIL rst_en_overlap: got rst=%0b en=%0b expected not both 1", cnt_rst, cnt_en);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sw, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            switches = sw;
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        logic [1:0] sw;
        int n;

        // Reset with switches low
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
        $display("[TB] reset released");
        applyStimulus(2'b00, 3);
        checkValue("clear_window", cnt_rst, 1);
        checkValue("clear_leds", leds, 15);
        applyStimulus(2'b00, 1);
        checkValue("idle_after_clear", state_o, 1);
        applyStimulus(2'b00, 4);
        checkValue("idle_leds", leds, 0);

        // Start running
        applyStimulus(2'b01, 3);
        checkValue("run_entry", state_o, 2);
        applyStimulus(2'b01, 3);
        checkValue("no_early_en", cnt_en, 0);
        applyStimulus(2'b01, 1);
        checkValue("first_en", cnt_en, 1);
        n = 0;
        while (m_cnt != 5 && n < 200) begin applyStimulus(2'b01, 1); n++; end
        checkValue("reach_5", counter_in, 5);

        // Pause and resume
        applyStimulus(2'b00, 8);
        checkValue("hold_state", state_o, 3);
        checkValue("hold_leds", leds, 5);
        applyStimulus(2'b01, 3);
        checkValue("resume_state", state_o, 2);
        applyStimulus(2'b01, 4);
        checkValue("resume_en", cnt_en, 1);
        applyStimulus(2'b01, 1);
        checkValue("resume_cnt", counter_in, 6);

        // Through the wrap
        n = 0;
        while (m_wraps == 0 && n < 400) begin applyStimulus(2'b01, 1); n++; end
`ifndef COUNTER_SEQ_AUTO_STOP_EN
        checkValue("first_wrap", wraps, 1);
        checkValue("wrap_cnt", counter_in, 0);
        applyStimulus(2'b01, 4);
        checkValue("after_wrap_cnt", counter_in, 1);
`endif

        // Clear edge with simultaneous run drop, then a second edge mid-clear
        applyStimulus(2'b10, 1);
        applyStimulus(2'b01, 1);
        applyStimulus(2'b11, 1);
        checkValue("clr_priority", state_o, 0);
        checkValue("clr_wraps", wraps, 0);
        applyStimulus(2'b11, 5);
        checkValue("clr_restart", state_o, 0);
        applyStimulus(2'b11, 1);
        checkValue("clr_exit_run", state_o, 2);

`ifndef COUNTER_SEQ_AUTO_STOP_EN
        // Long run to saturate the wrap counter
        n = 0;
        while (m_wraps < 255 && n < 20000) begin applyStimulus(2'b01, 1); n++; end
        checkValue("wrap_sat", wraps, 255);
        applyStimulus(2'b01, 2 * 16 * P);
        checkValue("wrap_sat_hold", wraps, 255);
`else
        n = 0;
        while (m_mode != 4 && n < 200) begin applyStimulus(2'b01, 1); n++; end
        checkValue("done_state", state_o, 4);
        applyStimulus(2'b01, 1);
        checkValue("done_leds", leds, 10);
        checkValue("done_cnt", counter_in, 15);
        applyStimulus(2'b00, 5);
        applyStimulus(2'b01, 5);
        checkValue("done_ignores_sw0", state_o, 4);
        applyStimulus(2'b11, 3);
        checkValue("done_clear", state_o, 0);
        applyStimulus(2'b01, 6);
`endif

        // Asynchronous reset in the middle of a cycle
        applyStimulus(2'b01, 10);
        #2 rst_n = 1'b0;
        #1;
        checkValue("async_rst_cnt_rst", cnt_rst, 1);
        checkValue("async_rst_cnt_en", cnt_en, 0);
        checkValue("async_rst_leds", leds, 0);
        checkValue("async_rst_wraps", wraps, 0);
        checkValue("async_rst_state", state_o, 0);
        repeat (2) @(negedge clk);
        modelReset();
        checkOutput();
        rst_n = 1'b1;
        applyStimulus(2'b01, 4);
        checkValue("post_reset_run", state_o, 2);

        // Random switch activity
        sw = 2'b01;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) sw[0] = ~sw[0];
            if ($urandom_range(0, 19) == 0) sw[1] = ~sw[1];
            applyStimulus(sw, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
